// File: rtl/line_memory_responder_if.sv
// Cache/memory line handshake: one request in flight, registered responses.
// dbg_state mirrors the responder FSM (0 = IDLE, 1 = BUSY) for checkers.
interface line_memory_responder_if #(
   parameter int DATA_W = 128
) ();
   // Handshake: a request is taken on a rising edge where is_input_valid and
   // mem_ready are both 1 and exactly one of mem_read/mem_write is 1; the
   // request inputs are don't-care while mem_ready is 0. Completion of a read is
   // a one-cycle is_output_valid pulse, of a write the return of mem_ready.
   logic              is_input_valid;
   logic [31:0]       addr;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] din;
   logic              is_output_valid;
   logic [DATA_W-1:0] dout;
   logic              mem_ready;
   logic              dbg_state;

   modport master (
      output is_input_valid, addr, mem_read, mem_write, din,
      input  is_output_valid, dout, mem_ready, dbg_state
   );

   modport slave (
      input  is_input_valid, addr, mem_read, mem_write, din,
      output is_output_valid, dout, mem_ready, dbg_state
   );
endinterface

// File: rtl/line_memory_responder.sv
// Line-granularity backing memory with fixed access latency; answers one
// cache miss-fill (read) or write-back (write) request at a time.
module line_memory_responder #(
   parameter int BLOCK_SIZE = 16,
   parameter int NUM_LINES  = 256,
   parameter int DELAY      = 4
) (
   input logic                         clk,
   input logic                         reset,
   line_memory_responder_if.slave      bus
);
   localparam int W         = BLOCK_SIZE * 8;
   localparam int ADDR_BITS = $clog2(NUM_LINES);
   localparam int CNT_W     = (DELAY > 1) ? $clog2(DELAY) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic                 rd_q, rd_d;
   logic [W-1:0]         din_q, din_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic [W-1:0]         dout_q, dout_d;
   logic                 mem_we;

   // Storage is deliberately not reset: it models main memory contents.
   logic [W-1:0]         mem_q [NUM_LINES];

   logic                 unused_addr_bits;
   assign unused_addr_bits = ^bus.addr[31:ADDR_BITS];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      din_d   = din_q;
      ready_d = ready_q;
      valid_d = 1'b0;
      dout_d  = dout_q;
      mem_we  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ready_q && bus.is_input_valid && (bus.mem_read ^ bus.mem_write)) begin
               addr_d  = bus.addr[ADDR_BITS-1:0];
               rd_d    = bus.mem_read;
               din_d   = bus.din;
               cnt_d   = CNT_W'(DELAY - 1);
               ready_d = 1'b0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               if (rd_q) begin
                  dout_d  = mem_q[addr_q];
                  valid_d = 1'b1;
               end else begin
                  mem_we  = 1'b1;
               end
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         din_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         din_q   <= din_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
      end
   end

   // mem_we comes from state_q, which reset forces to IDLE, so an abandoned
   // write never reaches the array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[addr_q] <= din_q;
      end
   end

   assign bus.mem_ready       = ready_q;
   assign bus.is_output_valid = valid_q;
   assign bus.dout            = dout_q;
   assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_line_memory_responder.sv
// Randomized transaction-level bench for line_memory_responder against a
// line-array reference model with an expected-read queue.
module tb_line_memory_responder;
  localparam int BLOCK_SIZE = 16;
  localparam int NUM_LINES  = 256;
  localparam int DELAY      = 4;
  localparam int W          = BLOCK_SIZE * 8;

  logic clk;
  logic reset;

  line_memory_responder_if #(.DATA_W(W)) bus ();

  line_memory_responder #(
    .BLOCK_SIZE(BLOCK_SIZE),
    .NUM_LINES (NUM_LINES),
    .DELAY     (DELAY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model and scoreboard
  logic [W-1:0] model_mem [NUM_LINES];
  bit           written [NUM_LINES];
  int           written_list[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_dout;
  int           n_checks;
  int           n_fail;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // driver: called at a negedge; returns at the negedge of the completion cycle
  task automatic issue(input bit rd, input logic [31:0] a, input logic [W-1:0] d);
    int low;
    int line;
    line = int'(a % NUM_LINES);
    check_eq("ready_at_issue", W'(bus.mem_ready), W'(1));
    bus.is_input_valid = 1'b1;
    bus.mem_read       = rd;
    bus.mem_write      = !rd;
    bus.addr           = a;
    bus.din            = d;
    if (rd) exp_q.push_back(model_mem[line]);
    @(negedge clk);
    bus.is_input_valid = $urandom_range(0, 1);
    bus.mem_read       = $urandom_range(0, 1);
    bus.mem_write      = $urandom_range(0, 1);
    bus.addr           = $urandom;
    bus.din            = rand_line();
    low = 0;
    while (bus.mem_ready !== 1'b1 && low < DELAY + 20) begin
      check_eq("busy_no_valid", W'(bus.is_output_valid), W'(0));
      check_eq("dout_hold", bus.dout, exp_dout);
      low++;
      @(negedge clk);
    end
    check_eq("busy_len", W'(low), W'(DELAY));
    bus.is_input_valid = 1'b0;
    if (rd) begin
      check_eq("read_valid", W'(bus.is_output_valid), W'(1));
      if (exp_q.size() > 0) exp_dout = exp_q.pop_front();
      check_eq("read_data", bus.dout, exp_dout);
    end else begin
      check_eq("write_no_valid", W'(bus.is_output_valid), W'(0));
      check_eq("write_dout_hold", bus.dout, exp_dout);
      model_mem[line] = d;
      if (!written[line]) begin
        written[line] = 1'b1;
        written_list.push_back(line);
      end
    end
  endtask

  // idle cycles, optionally presenting an illegal (both/neither) request
  task automatic idle(input int n, input bit illegal);
    for (int i = 0; i < n; i++) begin
      bus.is_input_valid = illegal;
      bus.mem_read       = $urandom_range(0, 1);
      bus.mem_write      = bus.mem_read;
      bus.addr           = $urandom;
      bus.din            = rand_line();
      @(negedge clk);
      check_eq("idle_ready", W'(bus.mem_ready), W'(1));
      check_eq("idle_no_valid", W'(bus.is_output_valid), W'(0));
      check_eq("idle_dout_hold", bus.dout, exp_dout);
    end
    bus.is_input_valid = 1'b0;
  endtask

  task automatic reset_mid_write();
    bus.is_input_valid = 1'b1;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b1;
    bus.addr           = 32'd7;
    bus.din            = '1;
    @(negedge clk);
    bus.is_input_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("rmw_busy", W'(bus.mem_ready), W'(0));
    reset = 1'b1;
    #1;
    check_eq("rmw_ready", W'(bus.mem_ready), W'(1));
    exp_dout = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [W-1:0] v0;
    logic [W-1:0] v1;
    logic [W-1:0] dead;
    n_checks = 0;
    n_fail   = 0;
    exp_dout = '0;
    reset    = 1'b0;
    bus.is_input_valid = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.addr      = '0;
    bus.din       = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      model_mem[i] = '0;
      written[i]   = 1'b0;
    end

    // reset seen before any clock edge
    #1 reset = 1'b1;
    #1;
    check_eq("rst_ready", W'(bus.mem_ready), W'(1));
    check_eq("rst_valid", W'(bus.is_output_valid), W'(0));
    check_eq("rst_dout", bus.dout, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // write then read
    dead = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    issue(1'b0, 32'd5, dead);
    idle(1, 1'b0);
    issue(1'b1, 32'd5, '0);
    idle(2, 1'b0);
    check_eq("wr_rd_literal", exp_dout, dead);

    // address wrap and illegal requests
    v0 = rand_line();
    issue(1'b0, NUM_LINES + 3, v0);
    issue(1'b1, 32'd3, '0);
    idle(3, 1'b1);
    issue(1'b1, 32'd3 + 4 * NUM_LINES, '0);
    idle(1, 1'b0);

    // back-to-back reads issued on the pulse cycle
    v0 = rand_line();
    v1 = ~v0;
    issue(1'b0, 32'd0, v0);
    issue(1'b0, 32'd1, v1);
    issue(1'b1, 32'd0, '0);
    issue(1'b1, 32'd1, '0);
    idle(2, 1'b0);

    // asynchronous reset mid-cycle clears outputs immediately
    #2 reset = 1'b1;
    #1;
    check_eq("async_rst_ready", W'(bus.mem_ready), W'(1));
    check_eq("async_rst_valid", W'(bus.is_output_valid), W'(0));
    check_eq("async_rst_dout", bus.dout, '0);
    exp_dout = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset during a write leaves the line untouched
    issue(1'b0, 32'd7, '0);
    reset_mid_write();
    issue(1'b1, 32'd7, '0);
    check_eq("rmw_line7_zero", bus.dout, '0);
    idle(1, 1'b0);

    // randomized traffic with wrapping addresses
    for (int t = 0; t < 60; t++) begin
      if (written_list.size() > 0 && $urandom_range(0, 1) == 1) begin
        int line;
        line = written_list[$urandom_range(0, written_list.size() - 1)];
        issue(1'b1, line + NUM_LINES * $urandom_range(0, 7), '0);
      end else begin
        issue(1'b0, $urandom, rand_line());
      end
      idle($urandom_range(0, 2), $urandom_range(0, 1) == 1);
    end

    check_eq("exp_q_empty", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
